// File: rtl/alu_seq_ctrl_if.sv
// Instruction, ALU-operand and writeback signals of the ALU sequencer.
// The slave modport is the sequencer side; the master side issues instructions and provides the ALU.
interface alu_seq_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [1:0] in_rd;
  logic [1:0] in_rs1;
  logic [1:0] in_rs2;
  logic       in_use_imm;
  logic [7:0] in_imm;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] opcode;
  logic [7:0] out;
  logic       res_valid;
  logic [7:0] res_data;
  logic [1:0] res_rd;
  logic       res_err;

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm, out,
    output in_ready, a, b, opcode, res_valid, res_data, res_rd, res_err
  );

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm, out,
    input  in_ready, a, b, opcode, res_valid, res_data, res_rd, res_err
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Three-state sequencer around an external combinational ALU: fetch operands from a
// 4 x 8-bit register file, capture the ALU result, then write it back.
module alu_seq_ctrl (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [3:0] OP_DIV = 4'b0011;

  state_t     state_reg;
  state_t     state_next;

  logic [7:0] rf_reg [4];
  logic [7:0] a_reg;
  logic [7:0] b_reg;
  logic [3:0] opcode_reg;
  logic [1:0] rd_reg;
  logic [7:0] res_data_reg;
  logic [1:0] res_rd_reg;
  logic       res_err_reg;

  logic       accept;
  logic       capture;
  logic       wb_en;
  logic       div_zero;
  logic [7:0] rs1_val;
  logic [7:0] rs2_val;

  // Next-state and per-state strobes
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    capture    = 1'b0;
    wb_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        capture    = 1'b1;
        state_next = WB;
      end
      WB: begin
        wb_en      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  assign rs1_val  = rf_reg[bus.in_rs1];
  assign rs2_val  = rf_reg[bus.in_rs2];

  // Operands and opcode stay on the ALU inputs until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      opcode_reg <= '0;
      rd_reg     <= '0;
    end else if (accept) begin
      a_reg      <= rs1_val;
      b_reg      <= bus.in_use_imm ? bus.in_imm : rs2_val;
      opcode_reg <= bus.in_op;
      rd_reg     <= bus.in_rd;
    end
  end

  assign div_zero = (opcode_reg == OP_DIV) && (b_reg == 8'h00);

  // Result registers hold between writebacks, so res_* stay stable while res_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data_reg <= '0;
      res_rd_reg   <= '0;
      res_err_reg  <= 1'b0;
    end else if (capture) begin
      res_data_reg <= div_zero ? 8'hFF : bus.out;
      res_rd_reg   <= rd_reg;
      res_err_reg  <= div_zero;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rf
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rf_reg[gi] <= '0;
        end else if (wb_en && (res_rd_reg == 2'(gi))) begin
          rf_reg[gi] <= res_data_reg;
        end
      end
    end
  endgenerate

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.a         = a_reg;
  assign bus.b         = b_reg;
  assign bus.opcode    = opcode_reg;
  assign bus.res_valid = (state_reg == WB);
  assign bus.res_data  = res_data_reg;
  assign bus.res_rd    = res_rd_reg;
  assign bus.res_err   = res_err_reg;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: behavioural ALU plus a register-file model,
// directed scenarios and randomized instruction streams.
module tb_alu_seq_ctrl;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;
  logic [7:0] mdl_rf [4];

  alu_seq_ctrl_if bus ();

  alu_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    case (op)
      4'h0: return x + y;
      4'h1: return x - y;
      4'h2: begin p = x * y; return p[7:0]; end
      4'h3: return (y == 0) ? 8'h5A : x / y;
      4'h4: return x & y;
      4'h5: return x | y;
      4'h6: return x ^ y;
      4'h7: return ~(x | y);
      4'h8: return {x[6:0], 1'b0};
      4'h9: return {1'b0, x[7:1]};
      4'hA: return x;
      4'hB: return y;
      4'hC: return ~x;
      4'hD: return x + 8'd1;
      4'hE: return x - 8'd1;
      default: return {x[6:0], x[7]};
    endcase
  endfunction

  // Downstream combinational ALU
  always_comb bus.out = alu_fn(bus.opcode, bus.a, bus.b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction and follow it through EXEC, WB and back to IDLE.
  task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic ui, input logic [7:0] imm);
    logic [7:0] ea, eb, er, prev;
    logic       ee;
    int         n;
    bus.in_op = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
    bus.in_use_imm = ui; bus.in_imm = imm; bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 8) begin tick(); n++; end
    tests++;
    if (bus.in_ready !== 1'b1) begin
      failed++;
      $display("FAIL accept_timeout: in_ready=%b required 1", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    ea = mdl_rf[rs1];
    eb = ui ? imm : mdl_rf[rs2];
    ee = (op == 4'h3) && (eb == 8'h00);
    er = ee ? 8'hFF : alu_fn(op, ea, eb);
    prev = bus.res_data;
    tick();
    bus.in_valid = 1'b0;
    tests++;
    if ({bus.a, bus.b, bus.opcode} !== {ea, eb, op}) begin
      failed++;
      $display("FAIL operands: a=%h b=%h op=%h required a=%h b=%h op=%h", bus.a, bus.b, bus.opcode, ea, eb, op);
    end
    tests++;
    if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.res_data !== prev) begin
      failed++;
      $display("FAIL exec_cycle: res_valid=%b in_ready=%b res_data=%h required 0 0 %h",
               bus.res_valid, bus.in_ready, bus.res_data, prev);
    end
    tick();
    tests++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== er || bus.res_rd !== rd || bus.res_err !== ee) begin
      failed++;
      $display("FAIL writeback: valid=%b data=%h rd=%0d err=%b required 1 %h %0d %b",
               bus.res_valid, bus.res_data, bus.res_rd, bus.res_err, er, rd, ee);
    end
    tick();
    tests++;
    if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.res_data !== er ||
        bus.res_rd !== rd || bus.res_err !== ee) begin
      failed++;
      $display("FAIL post_wb_hold: valid=%b ready=%b data=%h rd=%0d err=%b required 0 1 %h %0d %b",
               bus.res_valid, bus.in_ready, bus.res_data, bus.res_rd, bus.res_err, er, rd, ee);
    end
    mdl_rf[rd] = er;
    $display("[TB] op=%h rd=%0d a=%h b=%h -> res=%h err=%b", op, rd, ea, eb, bus.res_data, bus.res_err);
  endtask

  // Read a register through operand a (pass-a writes the same value back).
  task automatic check_reg(input logic [1:0] idx, input logic [7:0] exp, input string name);
    issue(4'hA, idx, idx, 2'd0, 1'b1, 8'h00);
    tests++;
    if (bus.a !== exp) begin
      failed++;
      $display("FAIL %s: r%0d=%h required %h", name, idx, bus.a, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0; bus.in_rs1 = '0;
    bus.in_rs2 = '0; bus.in_use_imm = 1'b0; bus.in_imm = '0;
    for (int i = 0; i < 4; i++) mdl_rf[i] = 8'h00;
    #1;
    tests++;
    if ({bus.a, bus.b, bus.opcode, bus.res_valid, bus.res_data, bus.res_rd, bus.res_err} !== 31'd0) begin
      failed++;
      $display("FAIL reset_outputs: a=%h b=%h op=%h v=%b d=%h rd=%0d e=%b required all 0",
               bus.a, bus.b, bus.opcode, bus.res_valid, bus.res_data, bus.res_rd, bus.res_err);
    end
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    tests++;
    if (bus.in_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      failed++;
      $display("FAIL reset_release: in_ready=%b res_valid=%b required 1 0", bus.in_ready, bus.res_valid);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_add_imm();
    issue(4'h0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05);
    issue(4'h0, 2'd2, 2'd1, 2'd0, 1'b1, 8'h03);
    tests++;
    if (bus.res_data !== 8'h08 || bus.res_rd !== 2'd2) begin
      failed++;
      $display("FAIL add_imm: res_data=%h res_rd=%0d required 08 2", bus.res_data, bus.res_rd);
    end
  endtask

  task automatic test_sub_wrap();
    issue(4'h0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h02);
    issue(4'h0, 2'd2, 2'd0, 2'd0, 1'b1, 8'h05);
    issue(4'h1, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00);
    tests++;
    if (bus.res_data !== 8'hFD) begin
      failed++;
      $display("FAIL sub_wrap: res_data=%h required fd", bus.res_data);
    end
    check_reg(2'd3, 8'hFD, "sub_wrap_r3");
  endtask

  task automatic test_div_zero();
    issue(4'h0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h10);
    issue(4'h3, 2'd2, 2'd1, 2'd0, 1'b1, 8'h00);
    tests++;
    if (bus.res_data !== 8'hFF || bus.res_err !== 1'b1) begin
      failed++;
      $display("FAIL div_zero: res_data=%h res_err=%b required ff 1", bus.res_data, bus.res_err);
    end
    check_reg(2'd2, 8'hFF, "div_zero_r2");
    issue(4'h3, 2'd2, 2'd1, 2'd0, 1'b1, 8'h04);
    tests++;
    if (bus.res_data !== 8'h04 || bus.res_err !== 1'b0) begin
      failed++;
      $display("FAIL div_by_4: res_data=%h res_err=%b required 04 0", bus.res_data, bus.res_err);
    end
  endtask

  task automatic test_back_to_back();
    int   acc9, acc, pulses, n;
    logic exp_rdy;
    bus.in_op = 4'hA; bus.in_rd = 2'd1; bus.in_rs1 = 2'd1; bus.in_rs2 = 2'd0;
    bus.in_use_imm = 1'b1; bus.in_imm = 8'h00; bus.in_valid = 1'b1;
    acc9 = 0; acc = 0; pulses = 0;
    for (int c = 0; c < 10; c++) begin
      exp_rdy = (c % 3 == 0);
      tests++;
      if (bus.in_ready !== exp_rdy) begin
        failed++;
        $display("FAIL ready_pattern: cycle %0d in_ready=%b required %b", c, bus.in_ready, exp_rdy);
      end
      if (bus.in_ready === 1'b1) begin
        acc++;
        if (c < 9) acc9++;
      end
      if (bus.res_valid === 1'b1) pulses++;
      tick();
    end
    bus.in_valid = 1'b0;
    tests++;
    if (acc9 !== 3 || acc !== 4 || pulses !== 3) begin
      failed++;
      $display("FAIL handshake_counts: accepts9=%0d accepts=%0d pulses=%0d required 3 4 3", acc9, acc, pulses);
    end
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 5) begin tick(); n++; end
    tests++;
    if (bus.res_valid !== 1'b1) begin
      failed++;
      $display("FAIL last_accept_wb: res_valid=%b required 1", bus.res_valid);
    end
    tick();
    $display("[TB] handshake: %0d accepts, %0d pulses in window", acc, pulses);
  endtask

  task automatic test_all_ops();
    logic [7:0] exp_tab [16];
    exp_tab = '{8'hCD, 8'hB9, 8'h9E, 8'h13, 8'h02, 8'hCB, 8'hC9, 8'h34,
                8'h86, 8'h61, 8'hC3, 8'h0A, 8'h3C, 8'hC4, 8'hC2, 8'h87};
    issue(4'hB, 2'd1, 2'd0, 2'd0, 1'b1, 8'hC3);
    for (int op = 0; op < 16; op++) begin
      issue(4'(op), 2'd3, 2'd1, 2'd0, 1'b1, 8'h0A);
      tests++;
      if (bus.res_data !== exp_tab[op] || bus.res_err !== 1'b0) begin
        failed++;
        $display("FAIL all_ops: op=%h res_data=%h err=%b required %h 0", op, bus.res_data, bus.res_err, exp_tab[op]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] imm;
    for (int i = 0; i < 24; i++) begin
      imm = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      issue(4'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), imm);
    end
  endtask

  task automatic test_mid_reset();
    issue(4'hB, 2'd2, 2'd0, 2'd0, 1'b1, 8'h77);
    bus.in_op = 4'hB; bus.in_rd = 2'd2; bus.in_use_imm = 1'b1; bus.in_imm = 8'h55; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tests++;
    if (bus.in_ready !== 1'b0) begin
      failed++;
      $display("FAIL mid_reset_accept: in_ready=%b required 0", bus.in_ready);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.a, bus.b, bus.opcode, bus.res_valid, bus.res_data, bus.res_rd, bus.res_err} !== 31'd0) begin
      failed++;
      $display("FAIL mid_reset_outputs: a=%h b=%h op=%h v=%b d=%h rd=%0d e=%b required all 0",
               bus.a, bus.b, bus.opcode, bus.res_valid, bus.res_data, bus.res_rd, bus.res_err);
    end
    for (int i = 0; i < 4; i++) mdl_rf[i] = 8'h00;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++;
      if (bus.res_valid !== 1'b0) begin
        failed++;
        $display("FAIL mid_reset_pulse: cycle %0d res_valid=%b required 0", c, bus.res_valid);
      end
    end
    #1;
    rst_n = 1'b1;
    tick();
    tests++;
    if (bus.in_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      failed++;
      $display("FAIL mid_reset_release: in_ready=%b res_valid=%b required 1 0", bus.in_ready, bus.res_valid);
    end
    check_reg(2'd2, 8'h00, "mid_reset_r2");
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    test_reset();
    test_add_imm();
    test_sub_wrap();
    test_div_zero();
    test_back_to_back();
    test_all_ops();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
